// File: rtl/interboard_msg_handler.sv
// Applies one decoded inter-board message at a time to the local board:
// sequences table/deck memory ops, tracks turn ownership and opponent hand size.
module interboard_msg_handler #(
  parameter int unsigned PLAYER     = 0,
  parameter int unsigned TABLE_COLS = 18,
  parameter int unsigned INIT_HAND  = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       msg_valid,
  input  logic [3:0] msg_type,
  input  logic [4:0] msg_block_x,
  input  logic [2:0] msg_block_y,
  input  logic [5:0] msg_card,
  input  logic [2:0] msg_sel_len,
  input  logic       msg_move_dir,
  input  logic       mem_ready,
  output logic       msg_ack,
  output logic       busy,
  output logic       mem_req,
  output logic [2:0] mem_op,
  output logic [4:0] mem_src_x,
  output logic [4:0] mem_dst_x,
  output logic [2:0] mem_y,
  output logic [5:0] mem_card,
  output logic       my_turn,
  output logic [6:0] opp_hand_cnt,
  output logic       table_rst_pulse,
  output logic       game_rst_pulse,
  output logic       cheat_pulse,
  output logic       err_pulse,
  output logic       done_pulse
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_MEM_OP   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [3:0] T_TABLE_TAKE  = 4'd0;
  localparam logic [3:0] T_TABLE_DOWN  = 4'd1;
  localparam logic [3:0] T_TABLE_SHIFT = 4'd2;
  localparam logic [3:0] T_HAND_TAKE   = 4'd3;
  localparam logic [3:0] T_HAND_DRAW   = 4'd4;
  localparam logic [3:0] T_DECK_DRAW   = 4'd5;
  localparam logic [3:0] T_DECK_DOWN   = 4'd6;
  localparam logic [3:0] T_TURN        = 4'd7;
  localparam logic [3:0] T_RST_TABLE   = 4'd8;
  localparam logic [3:0] T_RST_GAME    = 4'd9;
  localparam logic [3:0] T_CHEAT       = 4'd10;

  localparam logic [2:0] OP_REMOVE   = 3'd0;
  localparam logic [2:0] OP_PLACE    = 3'd1;
  localparam logic [2:0] OP_MOVE     = 3'd2;
  localparam logic [2:0] OP_DECK_CLR = 3'd3;
  localparam logic [2:0] OP_DECK_SET = 3'd4;

  localparam logic [6:0] HAND_MAX    = 7'd106;
  localparam logic [6:0] HAND_RST    = 7'(INIT_HAND);
  localparam logic       TURN_RST    = (PLAYER == 0) ? 1'b1 : 1'b0;
  localparam logic [5:0] COLS_C      = 6'(TABLE_COLS);

  // Right shifts move the highest column first, left shifts the lowest first.
  function automatic logic [4:0] shift_src(input logic [4:0] x, input logic [2:0] len,
                                           input logic dir, input logic [2:0] idx);
    logic [5:0] s;
    if (dir) begin
      s = {1'b0, x} + {3'b000, len} - 6'd1 - {3'b000, idx};
    end else begin
      s = {1'b0, x} + {3'b000, idx};
    end
    return s[4:0];
  endfunction

  function automatic logic [4:0] shift_dst(input logic [4:0] src, input logic dir);
    return dir ? (src + 5'd1) : (src - 5'd1);
  endfunction

  logic [1:0] state_q, state_d;
  logic [3:0] type_q, type_d;
  logic [4:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic [5:0] card_q, card_d;
  logic [2:0] len_q, len_d;
  logic       dir_q, dir_d;
  logic [2:0] op_idx_q, op_idx_d;
  logic       msg_ack_q, msg_ack_d;
  logic       mem_req_q, mem_req_d;
  logic [2:0] mem_op_q, mem_op_d;
  logic [4:0] mem_src_x_q, mem_src_x_d;
  logic [4:0] mem_dst_x_q, mem_dst_x_d;
  logic [2:0] mem_y_q, mem_y_d;
  logic [5:0] mem_card_q, mem_card_d;
  logic       my_turn_q, my_turn_d;
  logic [6:0] opp_q, opp_d;
  logic       trst_q, trst_d, grst_q, grst_d, cheat_q, cheat_d, err_q, err_d, done_q, done_d;

  logic [5:0] span_s;
  logic       shift_ok_s;
  logic       more_ops_s;
  logic [4:0] first_src_s;
  logic [4:0] next_src_s;

  assign span_s      = {1'b0, x_q} + {3'b000, len_q};
  assign shift_ok_s  = dir_q ? (span_s <= (COLS_C - 6'd1))
                             : ((x_q != 5'd0) && (span_s <= COLS_C));
  assign more_ops_s  = (type_q == T_TABLE_SHIFT) && (op_idx_q != (len_q - 3'd1));
  assign first_src_s = shift_src(x_q, len_q, dir_q, 3'd0);
  assign next_src_s  = shift_src(x_q, len_q, dir_q, op_idx_q + 3'd1);

  // Next-state and next-output computation for the message FSM.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    x_d         = x_q;
    y_d         = y_q;
    card_d      = card_q;
    len_d       = len_q;
    dir_d       = dir_q;
    op_idx_d    = op_idx_q;
    msg_ack_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_op_d    = mem_op_q;
    mem_src_x_d = mem_src_x_q;
    mem_dst_x_d = mem_dst_x_q;
    mem_y_d     = mem_y_q;
    mem_card_d  = mem_card_q;
    my_turn_d   = my_turn_q;
    opp_d       = opp_q;
    trst_d      = 1'b0;
    grst_d      = 1'b0;
    cheat_d     = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          type_d    = msg_type;
          x_d       = msg_block_x;
          y_d       = msg_block_y;
          card_d    = msg_card;
          len_d     = msg_sel_len;
          dir_d     = msg_move_dir;
          msg_ack_d = 1'b1;
          state_d   = S_DISPATCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DISPATCH: begin
        state_d     = S_DONE;
        op_idx_d    = 3'd0;
        mem_dst_x_d = 5'd0;
        case (type_q)
          T_TABLE_TAKE: begin
            mem_req_d = 1'b1; mem_op_d = OP_REMOVE; mem_src_x_d = x_q;
            mem_y_d = y_q; mem_card_d = 6'd0; state_d = S_MEM_OP;
          end
          T_TABLE_DOWN: begin
            mem_req_d = 1'b1; mem_op_d = OP_PLACE; mem_src_x_d = x_q;
            mem_y_d = y_q; mem_card_d = card_q; state_d = S_MEM_OP;
          end
          T_TABLE_SHIFT: begin
            if (len_q == 3'd0) begin
              state_d = S_DONE;
            end else if (shift_ok_s) begin
              mem_req_d = 1'b1; mem_op_d = OP_MOVE; mem_src_x_d = first_src_s;
              mem_dst_x_d = shift_dst(first_src_s, dir_q); mem_y_d = y_q;
              mem_card_d = 6'd0; state_d = S_MEM_OP;
            end else begin
              err_d = 1'b1;
            end
          end
          T_HAND_TAKE: begin
            if (opp_q != 7'd0) begin
              opp_d = opp_q - 7'd1;
            end else begin
              opp_d = opp_q;
            end
          end
          T_HAND_DRAW: begin
            if (opp_q < HAND_MAX) begin
              opp_d = opp_q + 7'd1;
            end else begin
              opp_d = opp_q;
            end
          end
          T_DECK_DRAW: begin
            mem_req_d = 1'b1; mem_op_d = OP_DECK_CLR; mem_src_x_d = 5'd0;
            mem_y_d = 3'd0; mem_card_d = card_q; state_d = S_MEM_OP;
          end
          T_DECK_DOWN: begin
            mem_req_d = 1'b1; mem_op_d = OP_DECK_SET; mem_src_x_d = 5'd0;
            mem_y_d = 3'd0; mem_card_d = card_q; state_d = S_MEM_OP;
          end
          T_TURN:      my_turn_d = ~my_turn_q;
          T_RST_TABLE: trst_d = 1'b1;
          T_RST_GAME: begin
            grst_d    = 1'b1;
            my_turn_d = TURN_RST;
            opp_d     = HAND_RST;
          end
          T_CHEAT:     cheat_d = 1'b1;
          default:     err_d = 1'b1;
        endcase
      end
      S_MEM_OP: begin
        if (mem_ready) begin
          if (more_ops_s) begin
            op_idx_d    = op_idx_q + 3'd1;
            mem_src_x_d = next_src_s;
            mem_dst_x_d = shift_dst(next_src_s, dir_q);
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_DONE;
          end
        end else begin
          state_d = S_MEM_OP;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; either reset source abandons any in-flight op.
  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q     <= S_IDLE;
      type_q      <= 4'd0;
      x_q         <= 5'd0;
      y_q         <= 3'd0;
      card_q      <= 6'd0;
      len_q       <= 3'd0;
      dir_q       <= 1'b0;
      op_idx_q    <= 3'd0;
      msg_ack_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_op_q    <= 3'd0;
      mem_src_x_q <= 5'd0;
      mem_dst_x_q <= 5'd0;
      mem_y_q     <= 3'd0;
      mem_card_q  <= 6'd0;
      my_turn_q   <= TURN_RST;
      opp_q       <= HAND_RST;
      trst_q      <= 1'b0;
      grst_q      <= 1'b0;
      cheat_q     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      x_q         <= x_d;
      y_q         <= y_d;
      card_q      <= card_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      op_idx_q    <= op_idx_d;
      msg_ack_q   <= msg_ack_d;
      mem_req_q   <= mem_req_d;
      mem_op_q    <= mem_op_d;
      mem_src_x_q <= mem_src_x_d;
      mem_dst_x_q <= mem_dst_x_d;
      mem_y_q     <= mem_y_d;
      mem_card_q  <= mem_card_d;
      my_turn_q   <= my_turn_d;
      opp_q       <= opp_d;
      trst_q      <= trst_d;
      grst_q      <= grst_d;
      cheat_q     <= cheat_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign msg_ack         = msg_ack_q;
  assign busy            = (state_q != S_IDLE);
  assign mem_req         = mem_req_q;
  assign mem_op          = mem_op_q;
  assign mem_src_x       = mem_src_x_q;
  assign mem_dst_x       = mem_dst_x_q;
  assign mem_y           = mem_y_q;
  assign mem_card        = mem_card_q;
  assign my_turn         = my_turn_q;
  assign opp_hand_cnt    = opp_q;
  assign table_rst_pulse = trst_q;
  assign game_rst_pulse  = grst_q;
  assign cheat_pulse     = cheat_q;
  assign err_pulse       = err_q;
  assign done_pulse      = done_q;

endmodule

// File: tb/tb_interboard_msg_handler.sv
// Directed plus randomized bench for interboard_msg_handler against a
// message-level reference model (expected op lists, cycle counts, counters).
module tb_interboard_msg_handler;

  localparam int COLS = 18;

  logic       clk = 1'b0;
  logic       rst, interboard_rst, msg_valid, msg_move_dir, mem_ready;
  logic [3:0] msg_type;
  logic [4:0] msg_block_x;
  logic [2:0] msg_block_y, msg_sel_len;
  logic [5:0] msg_card;
  logic       msg_ack, busy, mem_req, my_turn;
  logic [2:0] mem_op, mem_y;
  logic [4:0] mem_src_x, mem_dst_x;
  logic [5:0] mem_card;
  logic [6:0] opp_hand_cnt;
  logic       table_rst_pulse, game_rst_pulse, cheat_pulse, err_pulse, done_pulse;

  int checks = 0;
  int errors = 0;
  int m_turn = 1;
  int m_hand = 14;

  interboard_msg_handler #(.PLAYER(0), .TABLE_COLS(COLS), .INIT_HAND(14)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .msg_valid(msg_valid),
    .msg_type(msg_type), .msg_block_x(msg_block_x), .msg_block_y(msg_block_y),
    .msg_card(msg_card), .msg_sel_len(msg_sel_len), .msg_move_dir(msg_move_dir),
    .mem_ready(mem_ready), .msg_ack(msg_ack), .busy(busy), .mem_req(mem_req),
    .mem_op(mem_op), .mem_src_x(mem_src_x), .mem_dst_x(mem_dst_x), .mem_y(mem_y),
    .mem_card(mem_card), .my_turn(my_turn), .opp_hand_cnt(opp_hand_cnt),
    .table_rst_pulse(table_rst_pulse), .game_rst_pulse(game_rst_pulse),
    .cheat_pulse(cheat_pulse), .err_pulse(err_pulse), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Keep only the fields that carry meaning for a given memory op.
  function automatic logic [21:0] norm(input logic [2:0] op, input logic [4:0] s, input logic [4:0] d,
                                       input logic [2:0] y, input logic [5:0] c);
    logic table_op;
    table_op = (op <= 3'd2);
    return {op, table_op ? s : 5'd0, (op == 3'd2) ? d : 5'd0, table_op ? y : 3'd0,
            (op == 3'd1 || op == 3'd3 || op == 3'd4) ? c : 6'd0};
  endfunction

  task automatic run_msg(input logic [3:0] t, input logic [4:0] x, input logic [2:0] y,
                         input logic [5:0] card, input logic [2:0] len, input logic dir,
                         input int stall, input bit hold_valid);
    logic [21:0] exp_q[$];
    logic [21:0] held, obs;
    int exp_err, exp_trst, exp_grst, exp_cheat, exp_done, n, s, d;
    int ack_n, ack_cyc, busy1, busy_done, req_first, done_cyc;
    int err_cyc, trst_cyc, grst_cyc, cheat_cyc, wait_n, got;
    exp_err = 0; exp_trst = 0; exp_grst = 0; exp_cheat = 0;
    ack_n = 0; ack_cyc = 0; busy1 = 0; busy_done = 1; req_first = 0; done_cyc = 0;
    err_cyc = 0; trst_cyc = 0; grst_cyc = 0; cheat_cyc = 0; wait_n = 0; got = 0;
    held = '0;
    case (t)
      4'd0: exp_q.push_back(norm(3'd0, x, 5'd0, y, card));
      4'd1: exp_q.push_back(norm(3'd1, x, 5'd0, y, card));
      4'd2: begin
        if (len != 3'd0) begin
          if (dir ? (int'(x) + int'(len) <= COLS - 1) : (x >= 5'd1 && int'(x) + int'(len) <= COLS)) begin
            for (int i = 0; i < int'(len); i++) begin
              s = dir ? (int'(x) + int'(len) - 1 - i) : (int'(x) + i);
              d = dir ? s + 1 : s - 1;
              exp_q.push_back(norm(3'd2, 5'(s), 5'(d), y, card));
            end
          end else begin
            exp_err = 1;
          end
        end
      end
      4'd3: if (m_hand > 0) m_hand = m_hand - 1;
      4'd4: if (m_hand < 106) m_hand = m_hand + 1;
      4'd5: exp_q.push_back(norm(3'd3, x, 5'd0, y, card));
      4'd6: exp_q.push_back(norm(3'd4, x, 5'd0, y, card));
      4'd7: m_turn = 1 - m_turn;
      4'd8: exp_trst = 1;
      4'd9: begin exp_grst = 1; m_turn = 1; m_hand = 14; end
      4'd10: exp_cheat = 1;
      default: exp_err = 1;
    endcase
    n = exp_q.size();
    exp_done = (n == 0) ? 3 : 3 + n * (stall + 1);

    @(negedge clk);
    msg_type = t; msg_block_x = x; msg_block_y = y; msg_card = card;
    msg_sel_len = len; msg_move_dir = dir; msg_valid = 1'b1;
    for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (msg_ack) begin
        ack_n++;
        if (ack_cyc == 0) ack_cyc = c;
        if (!hold_valid) msg_valid = 1'b0;
      end
      if (c == 1) busy1 = int'(busy);
      if (err_pulse && err_cyc == 0) err_cyc = c;
      if (table_rst_pulse && trst_cyc == 0) trst_cyc = c;
      if (game_rst_pulse && grst_cyc == 0) grst_cyc = c;
      if (cheat_pulse && cheat_cyc == 0) cheat_cyc = c;
      mem_ready = 1'b0;
      if (mem_req) begin
        if (req_first == 0) req_first = c;
        obs = norm(mem_op, mem_src_x, mem_dst_x, mem_y, mem_card);
        if (wait_n == 0) held = obs;
        else chk("mem_hold", obs, held);
        if (wait_n == stall) begin
          mem_ready = 1'b1;
          wait_n = 0;
          if (got < n) chk($sformatf("mem_op%0d_t%0d", got, t), obs, exp_q[got]);
          else chk("extra_op", got + 1, n);
          got++;
        end else begin
          wait_n++;
        end
      end
      if (done_pulse) begin
        done_cyc = c;
        busy_done = int'(busy);
        msg_valid = 1'b0;
      end
    end
    msg_valid = 1'b0;
    mem_ready = 1'b0;
    chk("ack_count", ack_n, 1);
    chk("ack_cycle", ack_cyc, 1);
    chk("busy_c1", busy1, 1);
    chk("op_count", got, n);
    chk("req_first", req_first, (n == 0) ? 0 : 2);
    chk($sformatf("done_cycle_t%0d", t), done_cyc, exp_done);
    chk("busy_after", busy_done, 0);
    chk("err_cycle", err_cyc, exp_err ? 2 : 0);
    chk("trst_cycle", trst_cyc, exp_trst ? 2 : 0);
    chk("grst_cycle", grst_cyc, exp_grst ? 2 : 0);
    chk("cheat_cycle", cheat_cyc, exp_cheat ? 2 : 0);
    chk("my_turn", my_turn, m_turn);
    chk("opp_hand", opp_hand_cnt, m_hand);
  endtask

  initial begin
    int done_first;
    rst = 1'b1; interboard_rst = 1'b0; msg_valid = 1'b0; mem_ready = 1'b0;
    msg_type = 4'd0; msg_block_x = 5'd0; msg_block_y = 3'd0; msg_card = 6'd0;
    msg_sel_len = 3'd0; msg_move_dir = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_fields", {mem_op, mem_src_x, mem_dst_x, mem_y, mem_card}, 0);
    chk("rst_pulses", {msg_ack, table_rst_pulse, game_rst_pulse, cheat_pulse, err_pulse, done_pulse}, 0);
    chk("rst_turn", my_turn, 1);
    chk("rst_hand", opp_hand_cnt, 14);

    run_msg(4'd1, 5'd4, 3'd2, 6'd37, 3'd0, 1'b0, 0, 1'b0);
    run_msg(4'd2, 5'd3, 3'd1, 6'd0, 3'd3, 1'b1, 2, 1'b0);
    run_msg(4'd2, 5'd0, 3'd0, 6'd0, 3'd2, 1'b0, 0, 1'b0);
    run_msg(4'd2, 5'd16, 3'd0, 6'd0, 3'd2, 1'b1, 0, 1'b0);
    run_msg(4'd2, 5'd15, 3'd5, 6'd0, 3'd2, 1'b1, 1, 1'b0);
    run_msg(4'd2, 5'd16, 3'd3, 6'd0, 3'd2, 1'b0, 0, 1'b0);
    run_msg(4'd2, 5'd9, 3'd0, 6'd0, 3'd0, 1'b1, 0, 1'b0);
    run_msg(4'd7, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    run_msg(4'd7, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 15; i++) run_msg(4'd3, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    run_msg(4'd9, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    run_msg(4'd12, 5'd7, 3'd1, 6'd9, 3'd1, 1'b1, 0, 1'b1);
    run_msg(4'd0, 5'd11, 3'd6, 6'd5, 3'd0, 1'b0, 1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_msg(4'($urandom_range(0, 15)), 5'($urandom_range(0, 19)), 3'($urandom_range(0, 7)),
              6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Move away from reset values, then clear from the link mid-shift.
    run_msg(4'd7, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    run_msg(4'd3, 5'd0, 3'd0, 6'd0, 3'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    msg_type = 4'd2; msg_block_x = 5'd3; msg_block_y = 3'd1; msg_sel_len = 3'd3;
    msg_move_dir = 1'b1; msg_valid = 1'b1;
    done_first = 0;
    for (int c = 1; c <= 20 && done_first == 0; c++) begin
      @(negedge clk);
      if (msg_ack) msg_valid = 1'b0;
      mem_ready = mem_req;
      if (mem_req) done_first = c;
    end
    chk("ibrst_first_op_cycle", done_first, 2);
    @(negedge clk);
    chk("ibrst_second_op_src", mem_src_x, 4);
    mem_ready = 1'b0;
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    chk("ibrst_mem_req", mem_req, 0);
    chk("ibrst_busy", busy, 0);
    chk("ibrst_turn", my_turn, 1);
    chk("ibrst_hand", opp_hand_cnt, 14);
    m_turn = 1;
    m_hand = 14;
    repeat (3) @(negedge clk);
    chk("ibrst_idle_quiet", {mem_req, busy, done_pulse}, 0);
    run_msg(4'd6, 5'd0, 3'd0, 6'd42, 3'd0, 1'b0, 1, 1'b0);
    run_msg(4'd2, 5'd5, 3'd2, 6'd0, 3'd4, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
